// File: rtl/auto_player.sv
// Automatic Connect Four opponent: picks a legal column and drives INC/DEC/OK pulses into the game core.
// Optional feature: define AUTO_PLAYER_LFSR_EN for an LFSR-randomised scan start instead of the fixed preference order.
module auto_player #(
    parameter int GAP        = 4,
    parameter int THINK      = 16,
    parameter int TIMEOUT    = 1023,
    parameter int COL_SIZE   = 3,
    parameter int FIELD_SIZE = 42
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  i_enable,
    input  logic                  i_side,
    input  logic [COL_SIZE-1:0]   i_selecting_col,
    input  logic [FIELD_SIZE-1:0] i_red_field,
    input  logic [FIELD_SIZE-1:0] i_blue_field,
    output logic [3:0]            o_user_input,
    output logic [2:0]            o_target_col,
    output logic                  o_busy,
    output logic                  o_no_move
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_THINK   = 3'd1;
    localparam logic [2:0] S_CHOOSE  = 3'd2;
    localparam logic [2:0] S_MOVE    = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_CONFIRM = 3'd5;
    localparam logic [2:0] S_WAIT    = 3'd6;

    localparam logic [3:0] CMD_NONE = 4'b0000;
    localparam logic [3:0] CMD_INC  = 4'b0001;
    localparam logic [3:0] CMD_DEC  = 4'b0010;
    localparam logic [3:0] CMD_OK   = 4'b0100;

    localparam int CNT_W   = $clog2(FIELD_SIZE + 1);
    localparam int THINK_W = $clog2(THINK + 1);
    localparam int GAP_W   = $clog2(GAP + 1);
    localparam int WAIT_W  = $clog2(TIMEOUT + 1);

    localparam logic [THINK_W-1:0] THINK_LAST = THINK_W'(THINK - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

    logic [2:0]            state;
    logic [THINK_W-1:0]    think_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [2:0]            scan_idx;
    logic [2:0]            cand;
    logic [CNT_W-1:0]      snap;
    logic [CNT_W-1:0]      n_red;
    logic [CNT_W-1:0]      n_blue;
    logic [CNT_W-1:0]      my_count;
    logic                  my_turn;
    logic [FIELD_SIZE-1:0] occupied;
    logic [7:0]            col_full;
    logic                  all_full;

    function automatic logic [CNT_W-1:0] popcount(input logic [FIELD_SIZE-1:0] field);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < FIELD_SIZE; i++) begin
            n = n + CNT_W'(field[i]);
        end
        return n;
    endfunction

    // Top-row occupancy marks a full column; index 7 is a phantom column that always reads full.
    assign occupied = i_red_field | i_blue_field;
    assign col_full = {1'b1, occupied[FIELD_SIZE-1 -: 7]};
    assign all_full = &col_full[6:0];
    assign n_red    = popcount(i_red_field);
    assign n_blue   = popcount(i_blue_field);
    assign my_count = i_side ? n_blue : n_red;
    assign my_turn  = i_side ? (n_red == n_blue + CNT_W'(1)) : (n_red == n_blue);
    assign o_busy   = (state != S_IDLE);

`ifdef AUTO_PLAYER_LFSR_EN
    logic [7:0] lfsr;
    logic [2:0] scan_start;
    logic [3:0] cand_sum;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            lfsr       <= 8'h5A;
            scan_start <= '0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (state == S_THINK && think_cnt == THINK_LAST) begin
                scan_start <= (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
            end
        end
    end

    // NOTE: every always_comb output gets a default before any condition, so no latch can be inferred.
    always_comb begin
        cand_sum = {1'b0, scan_start} + {1'b0, scan_idx};
        cand     = cand_sum[2:0];
        if (cand_sum >= 4'd7) begin
            cand = 3'(cand_sum - 4'd7);
        end
    end
`else
    function automatic logic [2:0] pref_col(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'd3;
            3'd1:    return 3'd2;
            3'd2:    return 3'd4;
            3'd3:    return 3'd1;
            3'd4:    return 3'd5;
            3'd5:    return 3'd0;
            default: return 3'd6;
        endcase
    endfunction

    assign cand = pref_col(scan_idx);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state        <= S_IDLE;
            o_user_input <= CMD_NONE;
            o_target_col <= '0;
            o_no_move    <= 1'b0;
            think_cnt    <= '0;
            gap_cnt      <= '0;
            wait_cnt     <= '0;
            scan_idx     <= '0;
            snap         <= '0;
        end else begin
            o_user_input <= CMD_NONE;
            o_no_move    <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_no_move <= my_turn && all_full;
                    if (i_enable && my_turn && !all_full) begin
                        state     <= S_THINK;
                        think_cnt <= '0;
                        snap      <= my_count;
                    end
                end
                S_THINK: begin
                    if (!i_enable) begin
                        state <= S_IDLE;
                    end else if (think_cnt == THINK_LAST) begin
                        state    <= S_CHOOSE;
                        scan_idx <= '0;
                    end else begin
                        think_cnt <= think_cnt + THINK_W'(1);
                    end
                end
                S_CHOOSE: begin
                    if (!i_enable) begin
                        state <= S_IDLE;
                    end else if (!col_full[cand]) begin
                        o_target_col <= cand;
                        state        <= S_MOVE;
                    end else if (scan_idx == 3'd6) begin
                        state <= S_IDLE;
                    end else begin
                        scan_idx <= scan_idx + 3'd1;
                    end
                end
                S_MOVE: begin
                    gap_cnt <= '0;
                    if (!i_enable) begin
                        state <= S_IDLE;
                    end else if (o_target_col == i_selecting_col) begin
                        state <= S_CONFIRM;
                    end else if (o_target_col > i_selecting_col) begin
                        o_user_input <= CMD_INC;
                        state        <= S_GAP;
                    end else if (i_selecting_col != '0) begin
                        o_user_input <= CMD_DEC;
                        state        <= S_GAP;
                    end
                end
                S_GAP: begin
                    // The cursor update from the pulse lands during this wait, before MOVE re-compares.
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_MOVE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_CONFIRM: begin
                    if (!i_enable) begin
                        state <= S_IDLE;
                    end else begin
                        o_user_input <= CMD_OK;
                        wait_cnt     <= '0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (my_count == snap + CNT_W'(1)) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_auto_player.sv
// Scoreboard bench for auto_player: a game-core model answers INC/DEC/OK, a reference picks the expected column.
module tb_auto_player;

    localparam int GAP = 4, THINK = 16, TIMEOUT = 1023, DROP = 256;
    localparam logic [3:0] C_INC = 4'b0001, C_DEC = 4'b0010, C_OK = 4'b0100;

    typedef struct packed {
        logic [3:0] cmd;
        logic [2:0] tgt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        side;
    logic [2:0]  sel;
    logic [41:0] red;
    logic [41:0] blue;
    logic [3:0]  user_input;
    logic [2:0]  target_col;
    logic        busy;
    logic        no_move;

    exp_t exp_q[$];
    int   pulse_times[$];
    int   ok_times[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   zeros;
    bit   ignore_ok;

    auto_player #(.GAP(GAP), .THINK(THINK), .TIMEOUT(TIMEOUT)) dut (
        .w_clk(clk), .w_rst(rst), .i_enable(enable), .i_side(side),
        .i_selecting_col(sel), .i_red_field(red), .i_blue_field(blue),
        .o_user_input(user_input), .o_target_col(target_col),
        .o_busy(busy), .o_no_move(no_move)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit col_is_full(input int c);
        logic [41:0] occ;
        occ = red | blue;
        return occ[35 + c];
    endfunction

    // Reference: first non-full column in the preference order 3,2,4,1,5,0,6.
    function automatic int model_target();
        int pref[7] = '{3, 2, 4, 1, 5, 0, 6};
        foreach (pref[i]) if (!col_is_full(pref[i])) return pref[i];
        return -1;
    endfunction

    function automatic bit dut_turn();
        int nr, nb;
        nr = $countones(red);
        nb = $countones(blue);
        return side ? (nr == nb + 1) : (nr == nb);
    endfunction

    task automatic place(input int c, input bit as_blue);
        logic [41:0] occ;
        occ = red | blue;
        for (int r = 0; r < 6; r++) begin
            if (!occ[r*7 + c]) begin
                if (as_blue) blue[r*7 + c] = 1'b1;
                else         red[r*7 + c]  = 1'b1;
                return;
            end
        end
        check("place_into_full_column", c, -1);
    endtask

    task automatic fill_col(input int c);
        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) red[r*7 + c] = 1'b1;
            else            blue[r*7 + c] = 1'b1;
        end
    endtask

    task automatic push_cmd(input logic [3:0] cmd, input int tgt);
        exp_t e;
        e.cmd = cmd;
        e.tgt = 3'(tgt);
        exp_q.push_back(e);
    endtask

    task automatic push_move(input int s);
        int t;
        t = model_target();
        for (int i = s; i < t; i++) push_cmd(C_INC, t);
        for (int i = s; i > t; i--) push_cmd(C_DEC, t);
        push_cmd(C_OK, t);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        red = '0;
        blue = '0;
        ignore_ok = 1'b0;
        exp_q.delete();
        pulse_times.delete();
        ok_times.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_move(input string name);
        int n;
        n = 0;
        while (!busy && n < 50) begin @(posedge clk); #1; n++; end
        check({name, "_busy_rise"}, int'(busy), 1);
        n = 0;
        while (busy && n < 4000) begin @(posedge clk); #1; n++; end
        check({name, "_busy_fall"}, int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic drop_stone(input int c);
        repeat (DROP) @(posedge clk);
        #1 if (!rst) place(c, side);
    endtask

    // Game-core model: cursor moves on the edge that samples the pulse; OK lands a stone DROP cycles later.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (user_input == C_INC) begin
                @(posedge clk);
                #1 if (sel < 3'd6) sel = sel + 3'd1;
            end else if (user_input == C_DEC) begin
                @(posedge clk);
                #1 if (sel > 3'd0) sel = sel - 3'd1;
            end else if (user_input == C_OK) begin
                if (ignore_ok) ignore_ok = 1'b0;
                else begin
                    automatic int cc = int'(sel);
                    fork drop_stone(cc); join_none
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every pulse and checks pulse shape and spacing.
    initial begin
        zeros = GAP;
        forever begin
            @(negedge clk);
            if (rst) begin
                zeros = GAP;
            end else if (user_input == 4'b0000) begin
                zeros++;
            end else begin
                check("pulse_legal", int'(user_input == C_INC || user_input == C_DEC || user_input == C_OK), 1);
                check("pulse_gap", int'(zeros >= GAP), 1);
                zeros = 0;
                pulse_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'(user_input), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("cmd", int'(user_input), int'(e.cmd));
                    if (e.cmd == C_OK) begin
                        check("ok_target", int'(target_col), int'(e.tgt));
                        ok_times.push_back(cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n, dut_moves, c;
        rst = 1'b1; enable = 1'b1; side = 1'b0; sel = '0;
        red = '0; blue = '0; ignore_ok = 1'b0;

        // 1: reset state, empty board, cursor at 0 -> INC x3 then OK on column 3
        do_reset();
        check("rst_user_input", int'(user_input), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_no_move", int'(no_move), 0);
        check("rst_target", int'(target_col), 0);
        t0 = cyc;
        sel = 3'd0;
        push_move(0);
        wait_move("t1");
        check("t1_first_pulse_seen", int'(pulse_times.size() > 0), 1);
        if (pulse_times.size() > 0)
            check("t1_latency_in_range",
                  int'(pulse_times[0] - t0 >= THINK + 1 && pulse_times[0] - t0 <= THINK + 10), 1);
        check("t1_red_count", $countones(red), 1);
        check("t1_target_hold", int'(target_col), 3);

        // 2: cursor at 5 -> DEC x2 then OK
        do_reset();
        sel = 3'd5;
        push_move(5);
        wait_move("t2");
        check("t2_pulse_count", pulse_times.size(), 3);

        // 3: column 3 full -> 2; columns 3,2,4,1,5,0 full -> 6
        do_reset();
        fill_col(3);
        sel = 3'($urandom_range(0, 6));
        push_move(int'(sel));
        wait_move("t3a");
        check("t3a_target", int'(target_col), 2);
        do_reset();
        fill_col(3); fill_col(2); fill_col(4); fill_col(1); fill_col(5); fill_col(0);
        sel = 3'($urandom_range(0, 6));
        push_move(int'(sel));
        wait_move("t3b");
        check("t3b_target", int'(target_col), 6);

        // 4: playing blue on a balanced board stays quiet until red moves
        side = 1'b1;
        do_reset();
        sel = 3'd0;
        repeat (1000) @(posedge clk);
        #1 check("t4_idle_busy", int'(busy), 0);
        check("t4_idle_pulses", pulse_times.size(), 0);
        sel = 3'($urandom_range(0, 6));
        push_move(int'(sel));
        red[0] = 1'b1;
        wait_move("t4");
        check("t4_blue_count", $countones(blue), 1);

        // 5: my turn but every column full
        side = 1'b0;
        do_reset();
        red  = (42'd1 << 35) | (42'd1 << 36) | (42'd1 << 37) | (42'd1 << 38);
        blue = (42'd1 << 39) | (42'd1 << 40) | (42'd1 << 41) | 42'd1;
        repeat (100) @(posedge clk);
        #1 check("t5_no_move", int'(no_move), 1);
        check("t5_busy", int'(busy), 0);
        check("t5_pulses", pulse_times.size(), 0);

        // 6: rejected OK -> timeout, retry with a bare OK, then the stone lands
        do_reset();
        sel = 3'd0;
        ignore_ok = 1'b1;
        push_move(0);
        push_cmd(C_OK, 3);
        n = 0;
        while (ok_times.size() < 2 && n < 3000) begin @(posedge clk); #1; n++; end
        check("t6_second_ok", ok_times.size(), 2);
        if (ok_times.size() == 2)
            check("t6_retry_interval",
                  int'(ok_times[1] - ok_times[0] >= TIMEOUT && ok_times[1] - ok_times[0] <= TIMEOUT + THINK + 20), 1);
        wait_move("t6");
        check("t6_red_count", $countones(red), 1);

        // 6b: reset asserted while a pulse is on the output
        do_reset();
        sel = 3'd0;
        push_move(0);
        n = 0;
        while (user_input == 4'b0000 && n < 100) begin @(posedge clk); #1; n++; end
        check("t6b_pulse_seen", int'(user_input), int'(C_INC));
        rst = 1'b1;
        #1 check("t6b_pulse_cut", int'(user_input), 0);
        check("t6b_busy_cut", int'(busy), 0);

        // Random game against a random opponent
        side = 1'($urandom_range(0, 1));
        do_reset();
        sel = 3'd0;
        dut_moves = 0;
        for (int ply = 0; ply < 18; ply++) begin
            if (model_target() < 0) break;
            if (dut_turn()) begin
                sel = 3'($urandom_range(0, 6));
                push_move(int'(sel));
                wait_move("rand");
                dut_moves++;
                check("rand_stone_count", side ? $countones(blue) : $countones(red), dut_moves);
            end else begin
                do c = $urandom_range(0, 6); while (col_is_full(c));
                place(c, !side);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/auto_player.md
# auto_player

Automatic opponent for the Connect Four game core. It is the driver side of the 4-bit user-input command interface that `m_manual_play` consumes, and it produces the same INC/DEC/OK pulses a human produces through the button front-end. It reads the red/blue fields and the selecting column back from the game core, picks a legal column, steers the cursor to it, confirms the move, and then waits until its stone has landed. A top-level mux selects between this block and the button path.

## Interface
- `GAP`, default 4: idle cycles after every command pulse (≥1).
- `THINK`, default 16: cycles spent in THINK before choosing.
- `TIMEOUT`, default 1023: WAIT_DONE cycles before retry (must exceed the 256-cycle piling delay).
- `w_clk` in 1: system clock.
- `w_rst` in 1: asynchronous, active-high reset.
- `i_enable` in 1: auto play allowed.
- `i_side` in 1: 0 = plays red, 1 = plays blue.
- `i_selecting_col` in `COL_SIZE`: cursor column from the game core, value 0..6.
- `i_red_field` in `FIELD_SIZE`: red stones.
- `i_blue_field` in `FIELD_SIZE`: blue stones.
- `o_user_input` out 4: command pulse. 4'b0001 INC, 4'b0010 DEC, 4'b0100 OK, else 0.
- `o_target_col` out 3: chosen column.
- `o_busy` out 1: block is not in IDLE.
- `o_no_move` out 1: it is this block's turn but all columns are full.

## Operation
- **Field layout:** bit `r*7+c` is row r (0 = bottom, 5 = top), column c. Column c is full when bit `35+c` of (red | blue) is set.
- **Turn detection:** nR and nB are the popcounts of the red and blue fields. Red's turn is nR==nB. Blue's turn is nR==nB+1. "My turn" is the turn matching `i_side`.
- **States:**
  - **IDLE:** `o_busy`=0. Go to THINK when `i_enable` is high, it is my turn, and at least one column is not full. If it is my turn and every column is full, set `o_no_move`=1 and stay in IDLE.
  - **THINK:** count `THINK` cycles, then go to CHOOSE. Snapshot my own popcount on entry.
  - **CHOOSE:** scan one candidate per cycle, at most 7 cycles. Latch the first non-full candidate into `o_target_col`, then go to MOVE. If no candidate is found, go to IDLE.
  - **MOVE:** compare the target with `i_selecting_col`.
    - Equal: go to CONFIRM.
    - Target greater: emit INC for one cycle, then wait `GAP` cycles.
    - Target smaller: emit DEC for one cycle, then wait `GAP` cycles.
    - Re-compare after each gap. DEC is never issued while `i_selecting_col`==0.
  - **CONFIRM:** emit OK for one cycle, then go to WAIT_DONE.
  - **WAIT_DONE:** go to IDLE when my popcount equals snapshot+1. If `TIMEOUT` cycles pass first (the game core rejected the move), go to IDLE to retry.
- **Disable:** `i_enable` low in THINK, CHOOSE or MOVE returns the block to IDLE after any pending gap. OK is never emitted while `i_enable` is 0.
- **`o_user_input`** is registered and carries at most one command bit per cycle. Every pulse is exactly one cycle wide and is followed by at least `GAP` zero cycles.

## Timing
- **Reset:** asynchronous. All outputs go to 0 immediately, and the state returns to IDLE. A reset in the middle of a pulse truncates the pulse in the same cycle.
- **Decision latency:** from the turn becoming mine to the first pulse is `THINK` + 1..7 (scan) + 1 cycles.
- **Cursor feedback:** the game core updates `i_selecting_col` on the edge that samples the pulse. Re-comparison happens after `GAP` cycles, which absorbs this update.
- **Field changes while busy:** the turn condition is evaluated only in IDLE. Field changes in other states are ignored, except for the popcount check in WAIT_DONE.
- **`o_target_col`** holds its value until the next CHOOSE.

## Configuration
- **`AUTO_PLAYER_LFSR_EN` defined:**
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'h5A on reset) advances every cycle.
  - CHOOSE starts at column `lfsr[2:0]` (7 maps to 0) and scans ascending with wrap-around.
- **Undefined:** CHOOSE uses the fixed preference order 3,2,4,1,5,0,6. No LFSR is instantiated.

## Test plan
The bench models the game core: it applies INC/DEC to `i_selecting_col` and, on OK, adds a stone 256 cycles later. LFSR is off unless stated.

1. Reset, empty board, side=0, enable=1, `i_selecting_col`=0 → target 3; three INC pulses, each followed by ≥4 zero cycles; then one OK; `o_busy` drops after the stone lands.
2. `i_selecting_col`=5, empty board → target 3; exactly two DEC pulses, then OK; no INC pulses.
3. Column 3 full (bit 38 set, stone counts balanced) → target 2. Columns 3,2,4,1,5,0 full → target 6.
4. side=1 with nR==nB → no pulses for 1000 cycles. Then add one red stone → the block moves and confirms.
5. All top-row bits set with it being my turn → `o_no_move`=1, `o_user_input` stays 0.
6. Game model ignores OK → after 1023 cycles the block returns to IDLE and repeats the sequence. Asserting `w_rst` mid-pulse → `o_user_input`=0 in the same cycle.
